// File: rtl/core_pip_ctrl.sv
// rtl/core_pip_ctrl.sv - pipeline valid/stall/flush control with sticky events and perf counters
module core_pip_ctrl #(
    parameter  int STAGES = 5,
    parameter  int CNT_W  = 32,
    localparam int SW     = $clog2(STAGES + 1)
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_IssueValid,
    input  logic [STAGES-1:0] i_StallReq,
    input  logic              i_FlushReq,
    input  logic [SW-1:0]     i_FlushStage,
    input  logic [STAGES-1:0] i_Event,
    input  logic [STAGES-1:0] i_IrqMask,
    input  logic              i_IrqAck,
    input  logic              i_CntClr,
    output logic [STAGES-1:0] o_StallEn,
    output logic [STAGES-1:0] o_FlushEn,
    output logic [STAGES-1:0] o_Valid,
    output logic              o_Interrupt,
    output logic [STAGES-1:0] o_EventLatch,
    output logic [CNT_W-1:0]  o_CycleCnt,
    output logic [CNT_W-1:0]  o_RetireCnt,
    output logic [CNT_W-1:0]  o_StallCnt
);

    logic [STAGES-1:0] stall_en;
    logic [STAGES-1:0] flush_en;
    logic [SW-1:0]     flush_lim;
    logic              retire;

    logic [STAGES-1:0] valid_d, valid_q;
    logic [STAGES-1:0] evt_d, evt_q;
    logic              irq_d, irq_q;
    logic [CNT_W-1:0]  cyc_d, cyc_q;
    logic [CNT_W-1:0]  ret_d, ret_q;
    logic [CNT_W-1:0]  stl_d, stl_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        return (en && (cnt != '1)) ? cnt + CNT_W'(1) : cnt;
    endfunction

    // A stall in an older stage freezes every younger stage behind it.
    always_comb begin
        logic acc;
        acc      = 1'b0;
        stall_en = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc         = acc | i_StallReq[k];
            stall_en[k] = acc;
        end
    end

    always_comb begin
        flush_lim = (i_FlushStage > SW'(STAGES)) ? SW'(STAGES) : i_FlushStage;
        flush_en  = '0;
        for (int k = 0; k < STAGES; k++) begin
            flush_en[k] = i_FlushReq & (SW'(k) < flush_lim);
        end
    end

    // Flush beats stall; an unstalled stage behind a stalled one takes a bubble.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = flush_en[0] ? 1'b0 : (stall_en[0] ? valid_q[0] : i_IssueValid);
        for (int k = 1; k < STAGES; k++) begin
            if (flush_en[k]) begin
                valid_d[k] = 1'b0;
            end else if (stall_en[k]) begin
                valid_d[k] = valid_q[k];
            end else begin
                valid_d[k] = valid_q[k-1] & ~stall_en[k-1];
            end
        end
    end

    always_comb begin
        retire = valid_q[STAGES-1] & ~stall_en[STAGES-1] & ~flush_en[STAGES-1];
        evt_d  = (i_IrqAck ? '0 : evt_q) | (i_Event & i_IrqMask);
        irq_d  = |evt_d;
        cyc_d  = i_CntClr ? '0 : sat_inc(cyc_q, 1'b1);
        ret_d  = i_CntClr ? '0 : sat_inc(ret_q, retire);
        stl_d  = i_CntClr ? '0 : sat_inc(stl_q, stall_en[0]);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            valid_q <= '0;
            evt_q   <= '0;
            irq_q   <= 1'b0;
            cyc_q   <= '0;
            ret_q   <= '0;
            stl_q   <= '0;
        end else begin
            valid_q <= valid_d;
            evt_q   <= evt_d;
            irq_q   <= irq_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            stl_q   <= stl_d;
        end
    end

    assign o_StallEn    = stall_en;
    assign o_FlushEn    = flush_en;
    assign o_Valid      = valid_q;
    assign o_Interrupt  = irq_q;
    assign o_EventLatch = evt_q;
    assign o_CycleCnt   = cyc_q;
    assign o_RetireCnt  = ret_q;
    assign o_StallCnt   = stl_q;

endmodule

// File: tb/tb_core_pip_ctrl.sv
// tb/tb_core_pip_ctrl.sv - scoreboard bench for core_pip_ctrl
module tb_core_pip_ctrl;

    localparam int S  = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue;
    logic [S-1:0]  stall_req;
    logic          flush_req;
    logic [2:0]    flush_stage;
    logic [S-1:0]  evt;
    logic [S-1:0]  mask;
    logic          ack;
    logic          clr;
    logic [S-1:0]  stall_en, flush_en, valid, evt_latch;
    logic          irq;
    logic [CW-1:0] cyc_cnt, ret_cnt, stl_cnt;

    core_pip_ctrl #(.STAGES(S), .CNT_W(CW)) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_IssueValid (issue),
        .i_StallReq   (stall_req),
        .i_FlushReq   (flush_req),
        .i_FlushStage (flush_stage),
        .i_Event      (evt),
        .i_IrqMask    (mask),
        .i_IrqAck     (ack),
        .i_CntClr     (clr),
        .o_StallEn    (stall_en),
        .o_FlushEn    (flush_en),
        .o_Valid      (valid),
        .o_Interrupt  (irq),
        .o_EventLatch (evt_latch),
        .o_CycleCnt   (cyc_cnt),
        .o_RetireCnt  (ret_cnt),
        .o_StallCnt   (stl_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [S-1:0]  valid;
        logic [S-1:0]  latch;
        logic          irq;
        logic [CW-1:0] cyc;
        logic [CW-1:0] ret;
        logic [CW-1:0] stl;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [S-1:0] m_valid  = '0;
    logic [S-1:0] m_latch  = '0;
    logic         m_irq    = 1'b0;
    int           m_cyc    = 0;
    int           m_ret    = 0;
    int           m_stl    = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // One clock: check combinational outputs, predict next state, push, clock, pop and compare.
    task automatic step();
        logic [S-1:0] e_stall, e_flush, n_valid, n_latch;
        int           lim;
        bit           retire;
        exp_t         e;
        #1;
        for (int k = 0; k < S; k++) begin
            e_stall[k] = 1'b0;
            for (int j = k; j < S; j++) if (stall_req[j]) e_stall[k] = 1'b1;
        end
        lim = (int'(flush_stage) > S) ? S : int'(flush_stage);
        for (int k = 0; k < S; k++) e_flush[k] = flush_req && (k < lim);
        check_val("stall_en", 64'(stall_en), 64'(e_stall));
        check_val("flush_en", 64'(flush_en), 64'(e_flush));
        if (rst) begin
            m_valid = '0; m_latch = '0; m_irq = 1'b0;
            m_cyc = 0; m_ret = 0; m_stl = 0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (e_flush[k])      n_valid[k] = 1'b0;
                else if (e_stall[k]) n_valid[k] = m_valid[k];
                else if (k == 0)     n_valid[k] = issue;
                else                 n_valid[k] = m_valid[k-1] & ~e_stall[k-1];
            end
            retire  = m_valid[S-1] && !e_stall[S-1] && !e_flush[S-1];
            n_latch = (ack ? '0 : m_latch) | (evt & mask);
            m_valid = n_valid;
            m_latch = n_latch;
            m_irq   = |n_latch;
            m_cyc   = clr ? 0 : sat(m_cyc + 1);
            m_ret   = clr ? 0 : sat(m_ret + (retire ? 1 : 0));
            m_stl   = clr ? 0 : sat(m_stl + (e_stall[0] ? 1 : 0));
        end
        e.valid = m_valid; e.latch = m_latch; e.irq = m_irq;
        e.cyc = CW'(m_cyc); e.ret = CW'(m_ret); e.stl = CW'(m_stl);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_val("valid",  64'(valid),     64'(e.valid));
            check_val("latch",  64'(evt_latch), 64'(e.latch));
            check_val("irq",    64'(irq),       64'(e.irq));
            check_val("cyc",    64'(cyc_cnt),   64'(e.cyc));
            check_val("ret",    64'(ret_cnt),   64'(e.ret));
            check_val("stl",    64'(stl_cnt),   64'(e.stl));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; issue = 1'b0; stall_req = '0; flush_req = 1'b0; flush_stage = '0;
        evt = '0; mask = '0; ack = 1'b0; clr = 1'b0;
        step();
        step();
        check_val("rst_valid", 64'(valid), 64'd0);
        check_val("rst_cyc", 64'(cyc_cnt), 64'd0);
        check_val("rst_irq", 64'(irq), 64'd0);
        rst = 1'b0;

        // Streaming fill
        issue = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i <= S) check_val("fill", 64'(valid), 64'((1 << i) - 1));
        end
        check_val("stream_stl", 64'(stl_cnt), 64'd0);
        step();
        check_val("stream_ret", 64'(ret_cnt), 64'd6);

        // Stall bubble
        stall_req = 5'b00100;
        #1 check_val("bubble_stall_en", 64'(stall_en), 64'b00111);
        step();
        check_val("bubble1", 64'(valid), 64'b10111);
        step();
        check_val("bubble2", 64'(valid), 64'b00111);
        check_val("bubble_stl", 64'(stl_cnt), 64'd2);
        stall_req = '0;
        repeat (S) step();
        check_val("refill", 64'(valid), 64'b11111);

        // Flush over stall, clamp, and no-op flush
        flush_req = 1'b1; flush_stage = 3'd3; stall_req = 5'b10000;
        #1 check_val("flush_en3", 64'(flush_en), 64'b00111);
        step();
        check_val("flush_valid", 64'(valid), 64'b11000);
        stall_req = '0; flush_stage = 3'd7;
        #1 check_val("flush_clamp", 64'(flush_en), 64'b11111);
        step();
        check_val("flush_all", 64'(valid), 64'b00000);
        flush_stage = 3'd0;
        #1 check_val("flush_zero", 64'(flush_en), 64'b00000);
        step();
        flush_req = 1'b0;

        // Sticky interrupt
        mask = 5'b00100; evt = 5'b00110;
        step();
        check_val("irq_latch", 64'(evt_latch), 64'b00100);
        check_val("irq_set", 64'(irq), 64'd1);
        evt = '0;
        step();
        ack = 1'b1; evt = 5'b00100;
        step();
        check_val("irq_ack_evt", 64'(irq), 64'd1);
        evt = '0;
        step();
        check_val("irq_ack", 64'(irq), 64'd0);
        ack = 1'b0; evt = 5'b00010;
        step();
        check_val("irq_masked", 64'(irq), 64'd0);
        evt = '0;

        // Saturation and clear
        repeat (300) step();
        check_val("sat_cyc", 64'(cyc_cnt), 64'd255);
        clr = 1'b1;
        step();
        check_val("clr_cyc", 64'(cyc_cnt), 64'd0);
        check_val("clr_ret", 64'(ret_cnt), 64'd0);
        clr = 1'b0;
        step();
        check_val("post_clr_cyc", 64'(cyc_cnt), 64'd1);

        // Random traffic, then reset mid-stream
        for (int i = 0; i < 40; i++) begin
            issue       = 1'($urandom);
            stall_req   = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
            flush_req   = ($urandom_range(0, 5) == 0);
            flush_stage = 3'($urandom_range(0, 7));
            evt         = S'($urandom);
            mask        = S'($urandom);
            ack         = ($urandom_range(0, 3) == 0);
            step();
        end
        flush_req = 1'b0; stall_req = 5'b00010; rst = 1'b1;
        #1 check_val("rst_stall_en", 64'(stall_en), 64'b00011);
        step();
        check_val("midrst_valid", 64'(valid), 64'd0);
        check_val("midrst_cyc", 64'(cyc_cnt), 64'd0);
        check_val("midrst_stl", 64'(stl_cnt), 64'd0);
        rst = 1'b0; stall_req = '0; issue = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_pip_ctrl.md
# core_pip_ctrl

Parametrised pipeline controller for the KayRV32 core, replacing the fixed three-stage event collector. It tracks a valid bit per stage and turns per-stage stall requests and the redirect flush into per-stage stall/flush enables for the IF..WB stage modules. It also latches stage events into a maskable sticky interrupt and keeps saturating cycle, retire and stall counters. It sits beside the pipeline stages in the core top; stage 0 is IF (youngest) and stage STAGES-1 is WB (oldest).

## Interface
- STAGES, 5, number of pipeline stages, 2..8
- CNT_W, 32, performance counter width, 8..64
- SW, $clog2(STAGES+1), width of the flush-boundary index (derived, not overridable)
- i_Clk  in  1  system clock, all logic on the rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_IssueValid  in  1  a new instruction is presented to stage 0 this cycle
- i_StallReq  in  STAGES  bit k: stage k cannot advance this cycle
- i_FlushReq  in  1  redirect (jump/branch) resolved this cycle
- i_FlushStage  in  SW  stage index that resolved the redirect; stages 0..i_FlushStage-1 are killed
- i_Event  in  STAGES  per-stage event pulses (exception, trap, ...)
- i_IrqMask  in  STAGES  event enable mask
- i_IrqAck  in  1  clears the interrupt and the event latch
- i_CntClr  in  1  clears all counters
- o_StallEn  out  STAGES  bit k: stage k holds its registers (combinational)
- o_FlushEn  out  STAGES  bit k: stage k clears its contents (combinational)
- o_Valid  out  STAGES  registered valid bit per stage
- o_Interrupt  out  1  sticky interrupt, registered
- o_EventLatch  out  STAGES  accumulated masked events, registered
- o_CycleCnt, o_RetireCnt, o_StallCnt  out  CNT_W each  saturating counters

## Operation
- Stall propagation: o_StallEn[k] = OR of i_StallReq[j] for all j >= k. An older stall freezes every younger stage.
- Flush: o_FlushEn[k] = i_FlushReq & (k < i_FlushStage). i_FlushStage values above STAGES are clamped to STAGES, which flushes all stages.
- Valid update, in priority order, for each stage k:
  - o_FlushEn[k] set: valid[k] <= 0. Flush wins over stall.
  - o_StallEn[k] set: valid[k] holds.
  - Otherwise: valid[k] <= (k==0 ? i_IssueValid : valid[k-1] & ~o_StallEn[k-1]).
  - Rule: a stalled younger stage with a free older stage inserts a bubble.
- Retire: fires when valid[STAGES-1] & ~o_StallEn[STAGES-1] & ~o_FlushEn[STAGES-1].
- Counters:
  - o_CycleCnt increments every cycle.
  - o_RetireCnt increments on retire.
  - o_StallCnt increments when o_StallEn[0] is set.
  - All counters saturate at 2^CNT_W-1.
  - i_CntClr zeroes all counters; clear has priority over increment.
- Events:
  - o_EventLatch <= (i_IrqAck ? 0 : o_EventLatch) | (i_Event & i_IrqMask).
  - o_Interrupt <= |next o_EventLatch.
  - An event arriving in the same cycle as the ack survives the ack: the latch and interrupt stay set.
  - Masked-out events have no effect.
- No internal FSM beyond the registered state (valid vector, event latch, counters); the control paths are pure functions of that state and the inputs.

## Timing
- Reset (i_Rst high at an edge): o_Valid=0, o_EventLatch=0, o_Interrupt=0, all counters=0.
- During reset: o_StallEn and o_FlushEn follow their inputs combinationally, but state does not update.
- Reset mid-operation discards in-flight valids; there is no drain.
- o_StallEn and o_FlushEn have zero latency: they are combinational from the inputs in the same cycle.
- o_Valid and o_Interrupt have 1-cycle latency from the causing input.
- An issued instruction with no stalls reaches o_Valid[STAGES-1] STAGES cycles after issue and retires in that cycle.
- i_FlushStage=0 with i_FlushReq high is a no-op.
- Counters reflect the previous edge: the first cycle after reset reads o_CycleCnt=0, the next reads 1.

## Test plan
- Streaming: STAGES=5, i_IssueValid=1 for 10 cycles with no stall. Required: o_Valid fills 00001→11111 over 5 cycles; o_RetireCnt=6 after cycle 10; o_StallCnt=0.
- Stall bubble: full pipe, i_StallReq[2]=1 for 2 cycles. Required: o_StallEn=00111 during the stall; o_Valid[3] drops to 0 for 2 cycles (bubble inserted); stages 0..2 hold; o_StallCnt=2.
- Flush over stall: full pipe, i_FlushReq=1, i_FlushStage=3, i_StallReq[4]=1 in the same cycle. Required: o_FlushEn=00111; next o_Valid=11000.
- Interrupt: i_IrqMask=00100, pulse i_Event=00110. Required: o_EventLatch=00100 and o_Interrupt=1 next cycle. Then i_IrqAck=1 together with i_Event=00100. Required: o_Interrupt stays 1. Ack alone then gives 0.
- Saturation/clear: CNT_W=8, run 300 cycles. Required: o_CycleCnt=255. Then i_CntClr=1 → 0. Then i_Rst=1 mid-stream → o_Valid=0 and all counters 0.
